icd_hist_seq: RTL and testbench

ICD_HIST_SEQ -- requirements
Module: icd_hist_seq

---
 rtl/icd_hist_seq.sv | 106 ++++++++++
 tb/tb_icd_hist_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/icd_hist_seq.sv
// icd_hist_seq: SPI command sequencer for a 32-bin histogram (ID, CLEAR, RUN, READ)
//   clk6x        in   48 MHz system clock, rising edge
//   resetn       in   synchronous active-low reset
//   rx_byte_i    in   received SPI byte, valid with a strobe
//   rx_hdr_en_i  in   strobe: header byte (opcode[7:4], argument[3:0])
//   rx_db_en_i   in   strobe: data byte
//   tx_byte_o    out  reply byte, valid while tx_en_o is high
//   tx_en_o      out  one-cycle reply load strobe, two cycles after the accepted strobe
//   histidx_o    out  histogram bin index
//   histcnt_i    in   counter value of bin histidx_o
//   run_hist_o   out  histogram accumulation enable
//   clear_hist_o out  one-cycle histogram clear pulse
module icd_hist_seq #(
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic        clk6x,
    input  logic        resetn,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_hdr_en_i,
    input  logic        rx_db_en_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_en_o,
    output logic [4:0]  histidx_o,
    input  logic [15:0] histcnt_i,
    output logic        run_hist_o,
    output logic        clear_hist_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_RLO  = 3'd2;
    localparam logic [2:0] S_RHI  = 3'd3;
    localparam logic [2:0] S_UNK  = 3'd4;
    logic [2:0]  state;
    logic [15:0] snap;
    logic        pend;
    logic        pend_cap;
    logic [7:0]  pend_byte;
    logic [3:0]  op;
    logic        unused_arg;
    assign op = rx_byte_i[7:4];
    assign unused_arg = ^rx_byte_i[3:1];
    // Stage 1 (strobe edge) decodes and updates control state; stage 2 (next edge)
    // loads the reply. A low-byte reply (pend_cap) is taken straight from histcnt_i
    // one cycle after the index settles, and the same value is kept in snap so the
    // following high byte is consistent even if the counter moves meanwhile.
    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state        <= S_IDLE;
            snap         <= 16'h0000;
            pend         <= 1'b0;
            pend_cap     <= 1'b0;
            pend_byte    <= 8'h00;
            tx_byte_o    <= 8'h00;
            tx_en_o      <= 1'b0;
            histidx_o    <= 5'd0;
            run_hist_o   <= 1'b0;
            clear_hist_o <= 1'b0;
        end else begin
            clear_hist_o <= 1'b0;
            pend         <= 1'b0;
            pend_cap     <= 1'b0;
            tx_en_o      <= pend;
            if (pend) tx_byte_o <= pend_cap ? histcnt_i[7:0] : pend_byte;
            if (pend && pend_cap) snap <= histcnt_i;
            if (rx_hdr_en_i) begin
                pend      <= 1'b1;
                pend_byte <= {(op == 4'h2) ? rx_byte_i[0] : run_hist_o, 3'b000, op};
                state     <= S_IDLE;
                case (op)
                    4'h0: state <= S_ID;
                    4'h1: clear_hist_o <= 1'b1;
                    4'h2: run_hist_o <= rx_byte_i[0];
                    4'h3: begin
                        histidx_o <= 5'd0;
                        pend_cap  <= 1'b1;
                        state     <= S_RHI;
                    end
                    default: state <= S_UNK;
                endcase
            end else if (rx_db_en_i) begin
                case (state)
                    S_ID: begin
                        pend      <= 1'b1;
                        pend_byte <= ID_BYTE;
                    end
                    S_UNK: begin
                        pend      <= 1'b1;
                        pend_byte <= 8'hFF;
                    end
                    S_RHI: begin
                        pend      <= 1'b1;
                        pend_byte <= snap[15:8];
                        histidx_o <= histidx_o + 5'd1;
                        state     <= S_RLO;
                    end
                    S_RLO: begin
                        pend     <= 1'b1;
                        pend_cap <= 1'b1;
                        state    <= S_RHI;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_icd_hist_seq.sv
// tb_icd_hist_seq: directed and randomized checks of icd_hist_seq against a command-level model
module tb_icd_hist_seq;
    logic        clk6x = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        rx_hdr_en_i = 1'b0;
    logic        rx_db_en_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        tx_en_o;
    logic [4:0]  histidx_o;
    logic [15:0] histcnt_i;
    logic        run_hist_o;
    logic        clear_hist_o;
    logic [15:0] mem [32];
    int errors = 0;
    int checks = 0;
    // model: mode 0 idle, 1 id, 2 unknown, 3 read stream
    int          m_mode;
    bit          m_hi;
    bit          m_run;
    int          m_idx;
    logic [15:0] m_snap;

    icd_hist_seq dut (
        .clk6x(clk6x), .resetn(resetn), .rx_byte_i(rx_byte_i),
        .rx_hdr_en_i(rx_hdr_en_i), .rx_db_en_i(rx_db_en_i),
        .tx_byte_o(tx_byte_o), .tx_en_o(tx_en_o), .histidx_o(histidx_o),
        .histcnt_i(histcnt_i), .run_hist_o(run_hist_o), .clear_hist_o(clear_hist_o)
    );

    assign histcnt_i = mem[histidx_o];
    always #5 clk6x = ~clk6x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_hi = 0; m_run = 0; m_idx = 0; m_snap = 16'h0;
    endtask

    task automatic strobe(input bit hdr, input logic [7:0] b);
        bit ex_tx = 0;
        bit ex_clr = 0;
        logic [7:0] ex_b = 8'h00;
        int extra = 0;
        logic [3:0] op;
        op = b[7:4];
        if (hdr) begin
            ex_tx = 1;
            m_mode = 0;
            case (op)
                4'h0: m_mode = 1;
                4'h1: ex_clr = 1;
                4'h2: m_run = b[0];
                4'h3: begin m_mode = 3; m_idx = 0; m_snap = mem[0]; m_hi = 1; end
                default: m_mode = 2;
            endcase
            ex_b = (op == 4'h3) ? m_snap[7:0] : {m_run, 3'b000, op};
        end else begin
            case (m_mode)
                1: begin ex_tx = 1; ex_b = 8'hA5; end
                2: begin ex_tx = 1; ex_b = 8'hFF; end
                3: begin
                    ex_tx = 1;
                    if (m_hi) begin
                        ex_b = m_snap[15:8];
                        m_idx = (m_idx + 1) % 32;
                    end else begin
                        m_snap = mem[m_idx];
                        ex_b = m_snap[7:0];
                    end
                    m_hi = !m_hi;
                end
                default: ;
            endcase
        end
        @(posedge clk6x); #1;
        rx_byte_i = b; rx_hdr_en_i = hdr; rx_db_en_i = !hdr;
        @(posedge clk6x); #1;
        rx_hdr_en_i = 0; rx_db_en_i = 0;
        check("run_t1", run_hist_o, m_run);
        check("idx_t1", histidx_o, m_idx);
        check("clr_t1", clear_hist_o, ex_clr);
        extra += tx_en_o;
        @(posedge clk6x); #1;
        check("tx_en_t2", tx_en_o, ex_tx);
        if (ex_tx) check("tx_byte_t2", tx_byte_o, ex_b);
        extra += clear_hist_o;
        repeat (5) begin
            @(posedge clk6x); #1;
            extra += tx_en_o + clear_hist_o;
        end
        check("extra_pulses", extra, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_en"}, tx_en_o, 0);
        check({tag, "_tx_byte"}, tx_byte_o, 0);
        check({tag, "_idx"}, histidx_o, 0);
        check({tag, "_run"}, run_hist_o, 0);
        check({tag, "_clr"}, clear_hist_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        model_reset();
        repeat (3) @(posedge clk6x);
        #1;
        check_reset_outputs("reset");
        resetn = 1;
        strobe(0, 8'h5A);
        strobe(1, 8'h21);
        strobe(1, 8'h10);
        strobe(1, 8'h20);
        strobe(1, 8'h21);
        mem[0] = 16'h1234;
        mem[1] = 16'hBEEF;
        strobe(1, 8'h30);
        for (int i = 0; i < 3; i++) strobe(0, 8'h00);
        strobe(1, 8'h00);
        strobe(0, 8'h11);
        strobe(0, 8'h22);
        strobe(1, 8'h70);
        strobe(0, 8'h33);
        strobe(1, 8'h31);
        for (int i = 1; i <= 66; i++) begin
            strobe(0, 8'h00);
            if (i == 10) mem[5] = ~mem[5];
        end
        mem[0] = 16'hC3A7;
        @(posedge clk6x); #1;
        rx_byte_i = 8'h30; rx_hdr_en_i = 1;
        @(posedge clk6x); #1;
        rx_hdr_en_i = 0; resetn = 0;
        @(posedge clk6x); #1;
        check_reset_outputs("midreset");
        rx_byte_i = 8'h21; rx_hdr_en_i = 1;
        @(posedge clk6x); #1;
        rx_hdr_en_i = 0;
        repeat (3) @(posedge clk6x);
        #1;
        check_reset_outputs("reset_strobe");
        resetn = 1;
        model_reset();
        strobe(0, 8'h44);
        for (int n = 0; n < 300; n++) begin
            int r;
            int o;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 31)] = 16'($urandom);
            if (r < 3) begin
                o = $urandom_range(0, 5);
                if (o > 3) o = $urandom_range(4, 15);
                strobe(1, {4'(o), 4'($urandom_range(0, 15))});
            end else begin
                strobe(0, 8'($urandom));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
